ring_router_demux: RTL and testbench
====================================

Name: ring_router_demux

Overview:
Ingress stage of a debug-ring router node; sits directly upstream of the router's output mux. Takes DII flits arriving from the previous ring node, inspects the destination field of each worm's header flit, and steers the whole worm either to the local module port or onward to the ring mux input. Each output is registered (one flit of buffering per output) so the ring path is cut between nodes.

Parameters:
DEST_LSB, 0, bit position of the destination ID within header flit data
DEST_WIDTH, 16, width of destination ID (equals full data width by default)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
id  input  16  this node's ring ID; static after reset
in_ring  input  dii_flit  flit from previous ring node (valid, last, data[15:0])
in_ring_ready  output  1  in_ring flit accepted this cycle when valid & ready
out_local  output  dii_flit  worms addressed to this node
out_local_ready  input  1  local sink accepts
out_ring  output  dii_flit  worms passing through; feeds the ring output mux
out_ring_ready  input  1  ring mux accepts

Behaviour:
- Single clock domain, clk; rst synchronous, active-high.
- Reset: state=NOWORM; both output registers empty (out_local.valid=0, out_ring.valid=0); data/last don't-care.
- Flit transfer on any interface = valid & ready in the same cycle.
- Header = first flit accepted in NOWORM. dest = in_ring.data[DEST_LSB +: DEST_WIDTH]; compared against id[DEST_WIDTH-1:0].
- State machine:
  - NOWORM: if in_ring.valid, target = LOCAL if dest==id else RING. in_ring_ready = target register can accept. On transfer: flit loaded into target register; if !last -> WORM_LOCAL/WORM_RING, else stay NOWORM (single-flit worm).
  - WORM_LOCAL: all flits go to local register; in_ring_ready = local can accept; on transfer of flit with last=1 -> NOWORM.
  - WORM_RING: same on ring register.
- Non-header flits never re-decode destination; data is forwarded unmodified.
- Output register (each port): "can accept" = empty OR (valid & downstream ready) this cycle. Load on input transfer; clear valid on output transfer without simultaneous load. Simultaneous drain+load keeps valid=1 with new flit. Full throughput: one flit/cycle sustained when downstream ready held high.
- Latency: flit accepted in cycle N appears on output in cycle N+1.
- in_ring_ready depends combinationally on the selected output's ready; never on in_ring.valid in worm states. No combinational path from in_ring.data to any output.
- Back-to-back worms: last flit of worm A and header of worm B may be accepted in consecutive cycles; B may target the other port while A's last flit still sits in its register (no cross-port blocking).
- Backpressure on one port must not stall flits already buffered on the other.
- in_ring.valid=0 mid-worm: state held, no transfer.
- Reset mid-worm: state and registers cleared in the same cycle; remaining flits of the partial worm arriving after reset are decoded as headers (upstream is reset together).
- Flits are never dropped or duplicated; order preserved per port.

Decomposition:
- dii_package: existing dii_flit; add DII_DEST_LSB/DII_DEST_WIDTH constants used as parameter defaults.
- Sub-module ring_router_slice: one-flit dii_flit pipeline register (in, in_ready, out, out_ready, clk, rst); instantiated twice. Demux FSM and decode stay in ring_router_demux.

Test Plan:
- id=0x0005; single-flit worm data=0x0005,last=1, both readies=1 -> out_local valid next cycle with 0x0005; out_ring never valid; in_ring_ready=1 throughout.
- id=0x0005; 3-flit worm {0x0003,0xAAAA,0xBBBB(last)} -> out_ring carries exactly those 3 flits in cycles N+1..N+3; out_local idle.
- Local worm {0x0005,0x1234(last)} then immediately ring worm {0x0009(last)} with out_local_ready=0 -> local holds 0x0005, in_ring_ready=0 for 0x1234; after ready=1 local delivers 0x0005,0x1234; then 0x0009 on ring; 0x1234 never misrouted despite not matching id.
- Ring worm in progress, out_ring_ready toggled 1,0,1,0 with random in_ring.valid gaps -> all flits delivered in order, none lost/duplicated, state returns NOWORM after last.
- Header 0x0005 + 1 body accepted, rst asserted 1 cycle -> both outputs valid=0 next cycle; next flit 0x0007 treated as header, routed to ring.
- Sustained 100 single-flit worms alternating dest 0x0005/0x0002, both readies=1 -> 100 flits out (50 per port), one accepted per cycle, in_ring_ready never deasserts.

Source files
------------

// File: rtl/dii_package.sv
// Debug-ring flit type and the default placement of the
// destination ID inside a header flit.
package dii_package;

  typedef struct packed {
    logic        valid;
    logic        last;
    logic [15:0] data;
  } dii_flit;

  localparam int DII_DEST_LSB   = 0;
  localparam int DII_DEST_WIDTH = 16;

  typedef enum logic [1:0] {
    NOWORM,
    WORM_LOCAL,
    WORM_RING
  } demux_state_e;

endpackage

// File: rtl/ring_router_slice.sv
// One-flit pipeline register with full-throughput
// valid/ready handshake on both sides.
module ring_router_slice
  import dii_package::*;
(
  input  logic    clk,
  input  logic    rst,
  input  dii_flit in,
  output logic    in_ready,
  output dii_flit out,
  input  logic    out_ready
);

  dii_flit flit_q, flit_d;

  assign in_ready = !flit_q.valid || out_ready;
  assign out      = flit_q;

  always_comb begin
    flit_d = flit_q;
    if (in.valid && in_ready) begin
      flit_d = in;
    end else if (out_ready) begin
      flit_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flit_q <= '0;
    end else begin
      flit_q <= flit_d;
    end
  end

endmodule

// File: rtl/ring_router_demux.sv
// Ring router ingress: decodes each worm's header and
// steers the whole worm to the local or ring output.
module ring_router_demux
  import dii_package::*;
#(
  parameter int DEST_LSB   = DII_DEST_LSB,
  parameter int DEST_WIDTH = DII_DEST_WIDTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] id,
  input  dii_flit     in_ring,
  output logic        in_ring_ready,
  output dii_flit     out_local,
  input  logic        out_local_ready,
  output dii_flit     out_ring,
  input  logic        out_ring_ready
);

  demux_state_e state_q, state_d;

  logic    hit;
  logic    sel_local;
  logic    xfer;
  logic    loc_rdy;
  logic    ring_rdy;
  dii_flit loc_in;
  dii_flit ring_in;

  assign hit = in_ring.data[DEST_LSB +: DEST_WIDTH]
            == id[DEST_WIDTH-1:0];

  always_comb begin
    sel_local     = 1'b0;
    in_ring_ready = 1'b0;
    xfer          = 1'b0;
    state_d       = state_q;
    unique case (state_q)
      NOWORM:     sel_local = hit;
      WORM_LOCAL: sel_local = 1'b1;
      WORM_RING:  sel_local = 1'b0;
      default:    sel_local = 1'b0;
    endcase
    in_ring_ready = sel_local ? loc_rdy : ring_rdy;
    xfer          = in_ring.valid && in_ring_ready;
    unique case (state_q)
      NOWORM: begin
        if (xfer && !in_ring.last) begin
          state_d = hit ? WORM_LOCAL : WORM_RING;
        end
      end
      WORM_LOCAL, WORM_RING: begin
        if (xfer && in_ring.last) begin
          state_d = NOWORM;
        end
      end
      default: state_d = NOWORM;
    endcase
  end

  always_comb begin
    loc_in        = in_ring;
    loc_in.valid  = in_ring.valid && sel_local;
    ring_in       = in_ring;
    ring_in.valid = in_ring.valid && !sel_local;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= NOWORM;
    end else begin
      state_q <= state_d;
    end
  end

  ring_router_slice u_local (
    .clk       (clk),
    .rst       (rst),
    .in        (loc_in),
    .in_ready  (loc_rdy),
    .out       (out_local),
    .out_ready (out_local_ready)
  );

  ring_router_slice u_ring (
    .clk       (clk),
    .rst       (rst),
    .in        (ring_in),
    .in_ready  (ring_rdy),
    .out       (out_ring),
    .out_ready (out_ring_ready)
  );

endmodule

// File: tb/tb_ring_router_demux.sv
// Directed bench for ring_router_demux with a routing
// model feeding per-port expected-flit queues.
module tb_ring_router_demux;
  import dii_package::*;

  localparam logic [15:0] ID = 16'h0005;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] id;
  dii_flit     in_ring;
  logic        in_ring_ready;
  dii_flit     out_local;
  logic        out_local_ready;
  dii_flit     out_ring;
  logic        out_ring_ready;

  int n_assert = 0;
  int n_fail   = 0;
  int cnt_loc  = 0;
  int cnt_ring = 0;
  int tb_st    = 0;
  bit toggle_ring = 1'b0;
  int w;

  logic [16:0] q_loc[$];
  logic [16:0] q_ring[$];
  logic [15:0] t2[3];

  always #5 clk = ~clk;

  ring_router_demux dut (
    .clk             (clk),
    .rst             (rst),
    .id              (id),
    .in_ring         (in_ring),
    .in_ring_ready   (in_ring_ready),
    .out_local       (out_local),
    .out_local_ready (out_local_ready),
    .out_ring        (out_ring),
    .out_ring_ready  (out_ring_ready)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (toggle_ring) out_ring_ready = ~out_ring_ready;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // Holds the flit until accepted, then predicts its port.
  task automatic send(input logic [15:0] d,
                      input logic l,
                      output int waits);
    int port;
    in_ring.valid = 1'b1;
    in_ring.data  = d;
    in_ring.last  = l;
    waits = 0;
    #1;
    while (!in_ring_ready && waits < 100) begin
      tick();
      #1;
      waits++;
    end
    if (!in_ring_ready) begin
      check("send_accept", {31'd0, in_ring_ready}, 1);
      in_ring.valid = 1'b0;
      return;
    end
    if (tb_st == 0) begin
      port = (d == ID) ? 1 : 2;
      if (!l) tb_st = port;
    end else begin
      port = tb_st;
      if (l) tb_st = 0;
    end
    if (port == 1) q_loc.push_back({l, d});
    else q_ring.push_back({l, d});
    tick();
    in_ring.valid = 1'b0;
  endtask

  always begin
    @(negedge clk);
    #3;
    if (!rst) begin
      if (out_local.valid && out_local_ready) begin
        cnt_loc++;
        n_assert++;
        assert (q_loc.size() > 0) else begin
          n_fail++;
          $error("FAIL local_extra observed=%h expected=none",
                 out_local.data);
        end
        if (q_loc.size() > 0)
          check("local_flit",
                {out_local.last, out_local.data},
                q_loc.pop_front());
      end
      if (out_ring.valid && out_ring_ready) begin
        cnt_ring++;
        n_assert++;
        assert (q_ring.size() > 0) else begin
          n_fail++;
          $error("FAIL ring_extra observed=%h expected=none",
                 out_ring.data);
        end
        if (q_ring.size() > 0)
          check("ring_flit",
                {out_ring.last, out_ring.data},
                q_ring.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    id  = ID;
    in_ring = '0;
    out_local_ready = 1'b1;
    out_ring_ready  = 1'b1;
    idle(3);
    rst = 1'b0;
    tick();
    #1;
    check("rst_loc_valid", out_local.valid, 0);
    check("rst_ring_valid", out_ring.valid, 0);
    check("rst_in_ready", in_ring_ready, 1);

    // single-flit local worm
    send(16'h0005, 1'b1, w);
    check("t1_wait", w, 0);
    #1;
    check("t1_loc_valid", out_local.valid, 1);
    check("t1_loc_data", out_local.data, 16'h0005);
    check("t1_ring_valid", out_ring.valid, 0);
    idle(2);

    // three-flit ring worm, one flit per cycle
    t2[0] = 16'h0003;
    t2[1] = 16'hAAAA;
    t2[2] = 16'hBBBB;
    for (int i = 0; i < 3; i++) begin
      send(t2[i], i == 2, w);
      check("t2_wait", w, 0);
      #1;
      check("t2_ring_valid", out_ring.valid, 1);
      check("t2_ring_data", out_ring.data, t2[i]);
      check("t2_loc_valid", out_local.valid, 0);
    end
    idle(2);

    // local backpressure, then cross-port worm
    out_local_ready = 1'b0;
    send(16'h0005, 1'b0, w);
    fork
      send(16'h1234, 1'b1, w);
      begin
        repeat (2) begin
          @(negedge clk);
          #1;
          check("t3_ready_low", in_ring_ready, 0);
          check("t3_hold", out_local.data, 16'h0005);
        end
        @(negedge clk);
        out_local_ready = 1'b1;
      end
    join
    send(16'h0009, 1'b1, w);
    check("t3_ring_wait", w, 0);
    idle(4);
    check("t3_drain_loc", q_loc.size(), 0);
    check("t3_drain_ring", q_ring.size(), 0);

    // ring worm under toggling ready and input gaps
    toggle_ring = 1'b1;
    send(16'h0003, 1'b0, w);
    for (int i = 0; i < 8; i++) begin
      idle($urandom_range(0, 2));
      send(16'h0100 + 16'(i), i == 7, w);
    end
    toggle_ring = 1'b0;
    out_ring_ready = 1'b1;
    idle(5);
    check("t4_drain_ring", q_ring.size(), 0);
    send(16'h0005, 1'b1, w);
    #1;
    check("t4_noworm_local", out_local.valid, 1);
    idle(2);

    // reset in the middle of a local worm
    send(16'h0005, 1'b0, w);
    send(16'h0111, 1'b0, w);
    out_local_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q_loc.delete();
    q_ring.delete();
    tb_st = 0;
    #1;
    check("t5_loc_valid", out_local.valid, 0);
    check("t5_ring_valid", out_ring.valid, 0);
    out_local_ready = 1'b1;
    send(16'h0007, 1'b1, w);
    #1;
    check("t5_ring_valid2", out_ring.valid, 1);
    check("t5_ring_data", out_ring.data, 16'h0007);
    check("t5_loc_idle", out_local.valid, 0);
    idle(2);

    // sustained alternating single-flit worms
    cnt_loc  = 0;
    cnt_ring = 0;
    for (int i = 0; i < 100; i++) begin
      send((i % 2) ? 16'h0002 : 16'h0005, 1'b1, w);
      check("t6_wait", w, 0);
    end
    idle(3);
    check("t6_cnt_loc", cnt_loc, 50);
    check("t6_cnt_ring", cnt_ring, 50);
    check("end_q_loc", q_loc.size(), 0);
    check("end_q_ring", q_ring.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
